// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU op sequencer.
// master = sequencer side, slave = requester/ALU/consumer side.
interface alu_op_sequencer_if #(
  parameter int SIZE = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_command;
  logic [SIZE-1:0]   req_a;
  logic [SIZE-1:0]   req_b;
  logic              alu_enable;
  logic [3:0]        alu_command;
  logic [SIZE-1:0]   alu_a;
  logic [SIZE-1:0]   alu_b;
  logic              alu_overflow;
  logic [2*SIZE-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*SIZE-1:0] rsp_result;
  logic              rsp_overflow;
  logic              rsp_error;
  logic              busy;

  modport master (
    input  req_valid, req_command, req_a, req_b, alu_overflow, alu_result, rsp_ready,
    output req_ready, alu_enable, alu_command, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_overflow, rsp_error, busy
  );

  modport slave (
    output req_valid, req_command, req_a, req_b, alu_overflow, alu_result, rsp_ready,
    input  req_ready, alu_enable, alu_command, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_overflow, rsp_error, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered front-end for a combinational ALU: one request at a time, holds the
// ALU inputs for SETTLE_CYCLES with enable high, then returns the captured result.
module alu_op_sequencer #(
  parameter int SIZE          = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_CMD       = 6
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] MaxCmd  = 4'(MAX_CMD);
  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              alu_en_q;
  logic [3:0]        alu_cmd_q;
  logic [SIZE-1:0]   alu_a_q;
  logic [SIZE-1:0]   alu_b_q;
  logic              rsp_vld_q;
  logic [2*SIZE-1:0] rsp_res_q;
  logic              rsp_ovf_q;
  logic              rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_en_q  <= 1'b0;
      alu_cmd_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_res_q <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_command <= MaxCmd) begin
              alu_cmd_q <= bus.req_command;
              alu_a_q   <= bus.req_a;
              alu_b_q   <= bus.req_b;
              alu_en_q  <= 1'b1;
              cnt_q     <= CntInit;
              state_q   <= SETTLE;
            end else begin
              // Illegal opcode never reaches the ALU; answer with an error response.
              rsp_res_q <= '0;
              rsp_ovf_q <= 1'b0;
              rsp_err_q <= 1'b1;
              rsp_vld_q <= 1'b1;
              state_q   <= RESP;
            end
          end
        end
        SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_res_q <= bus.alu_result;
            rsp_ovf_q <= bus.alu_overflow;
            rsp_err_q <= 1'b0;
            rsp_vld_q <= 1'b1;
            alu_en_q  <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.alu_enable   = alu_en_q;
  assign bus.alu_command  = alu_cmd_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.rsp_valid    = rsp_vld_q;
  assign bus.rsp_result   = rsp_res_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_error    = rsp_err_q;
endmodule
